dsp_mul_arbiter: RTL and testbench
==================================

DSP_MUL_ARBITER -- requirements
Module: dsp_mul_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18, meaning multiplier A operand width.
REQ-002 SHALL have parameter B_WIDTH, default 18, meaning multiplier B operand width.
REQ-003 SHALL have parameter P_WIDTH, default 36, meaning product width returned by the DSP slice.
REQ-004 SHALL have parameter PIPE_LAT, default 4, range 1-8, meaning DSP cycles from dsp_ce to dsp_p valid.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports req0_valid/req1_valid  input  1 each  operand pair offered by requester 0/1.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1 each  requester 0/1 operand accepted this cycle.
REQ-009 SHALL have ports req0_a/req1_a  input  A_WIDTH each; req0_b/req1_b  input  B_WIDTH each  operands.
REQ-010 SHALL have ports dsp_a  output  A_WIDTH; dsp_b  output  B_WIDTH; dsp_ce  output  1  registered issue to DSP.
REQ-011 SHALL have port dsp_p  input  P_WIDTH  product from DSP, valid PIPE_LAT cycles after dsp_ce.
REQ-012 SHALL have ports rsp0_valid/rsp1_valid  output  1 each; rsp_p  output  P_WIDTH  routed result.
REQ-013 SHALL have ports flush  input  1  drain request; flush_done  output  1  one-cycle pulse when drained.

Function
REQ-014 SHALL accept at most one operand pair per cycle; handshake = reqN_valid & reqN_ready.
REQ-015 SHALL, in RUN, grant the single valid requester; if both valid, grant the one not granted last (round-robin); last-grant pointer resets to 1 so requester 0 wins first tie.
REQ-016 SHALL drive reqN_ready combinationally from valid, pointer and state; never both high.
REQ-017 SHALL register the granted operands onto dsp_a/dsp_b with dsp_ce=1 one cycle after handshake; dsp_ce=0 and dsp_a/dsp_b hold otherwise.
REQ-018 SHALL carry a (valid, id) tag through a PIPE_LAT+1 delay line so that rspN_valid and rsp_p (registered from dsp_p) assert exactly PIPE_LAT+2 cycles after handshake.
REQ-019 SHALL keep responses in issue order; responses have no backpressure.
REQ-020 SHALL implement FSM states RUN and DRAIN: RUN->DRAIN when flush=1; DRAIN blocks all grants; DRAIN->RUN when no tag valid in delay line, emitting flush_done=1 that cycle.
REQ-021 SHALL pulse flush_done one cycle after flush even if pipeline already empty; flush held high keeps state in DRAIN/re-enters after flush_done.
REQ-022 SHALL allow a handshake in the same cycle flush rises (flush is sampled for the next cycle).

Reset
REQ-023 SHALL on rst clear: state=RUN, pointer=1, delay-line tags, dsp_a=0, dsp_b=0, dsp_ce=0, rsp0_valid=rsp1_valid=0, rsp_p=0, flush_done=0.
REQ-024 SHALL discard in-flight tags on reset mid-operation; no response emitted for pre-reset issues.

Configuration
REQ-025 SHALL with macro DSP_ARB_GRANT_CNT_EN defined add outputs gnt_cnt0/gnt_cnt1 (16 bits each, reset 0, +1 per handshake, wrap 0xFFFF->0); without it those ports and counters do not exist.

Structure
REQ-026 SHALL place the FSM state enum (RUN, DRAIN) and default width constants in package dsp_arb_pkg.
REQ-027 SHALL build the tag delay line from the existing Register block, RST_TYPE="ASYNC", en=1, one instance per stage.

Verification (PIPE_LAT=4)
REQ-028 SHALL cover: req0 only, a=3 b=5 at cycle 0 -> dsp_ce at 1, rsp0_valid with rsp_p=15 at cycle 6.
REQ-029 SHALL cover: both valid 4 cycles -> grants 0,1,0,1; rsp0/rsp1 alternate at cycles 6-9.
REQ-030 SHALL cover: flush at cycle 2 with 2 issues in flight -> no ready during DRAIN, flush_done after last response.
REQ-031 SHALL cover: rst asserted at cycle 3 with issues in flight -> all outputs 0 immediately, no rspN_valid afterwards.
REQ-032 SHALL cover: macro defined, 65537 req0 handshakes -> gnt_cnt0=1, gnt_cnt1=0.

Source files
------------

// File: rtl/dsp_arb_pkg.sv
// Shared types and default widths for the DSP multiplier arbiter.
// Optional grant counters are enabled elsewhere by DSP_ARB_GRANT_CNT_EN.
package dsp_arb_pkg;

    localparam int DEF_A_WIDTH  = 18;
    localparam int DEF_B_WIDTH  = 18;
    localparam int DEF_P_WIDTH  = 36;
    localparam int DEF_PIPE_LAT = 4;
    localparam int GNT_CNT_W    = 16;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_e;

    // Tag carried alongside each DSP issue: {valid, requester id}
    localparam int TAG_W = 2;

endpackage

// File: rtl/dsp_mul_arbiter_register.sv
// Generic enable-gated register with selectable asynchronous or synchronous
// active-high reset; used as one stage of the arbiter's tag delay line.
module Register #(
    parameter int              WIDTH    = 1,
    parameter string           RST_TYPE = "ASYNC",
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    generate
        if (RST_TYPE == "ASYNC") begin : g_async
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)     q_q <= RST_VAL;
                else if (en_i) q_q <= d_i;
            end
        end else begin : g_sync
            always_ff @(posedge clk_i) begin
                if (rst_i)     q_q <= RST_VAL;
                else if (en_i) q_q <= d_i;
            end
        end
    endgenerate

    assign q_o = q_q;

endmodule

// File: rtl/dsp_mul_arbiter.sv
// Two-requester round-robin arbiter sharing one pipelined DSP multiplier, with
// in-order response routing and flush/drain. DSP_ARB_GRANT_CNT_EN adds grant counters.
module dsp_mul_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int A_WIDTH  = DEF_A_WIDTH,
    parameter int B_WIDTH  = DEF_B_WIDTH,
    parameter int P_WIDTH  = DEF_P_WIDTH,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [A_WIDTH-1:0] req0_a,
    input  logic [A_WIDTH-1:0] req1_a,
    input  logic [B_WIDTH-1:0] req0_b,
    input  logic [B_WIDTH-1:0] req1_b,
    output logic [A_WIDTH-1:0] dsp_a,
    output logic [B_WIDTH-1:0] dsp_b,
    output logic               dsp_ce,
    input  logic [P_WIDTH-1:0] dsp_p,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [P_WIDTH-1:0] rsp_p,
    input  logic               flush,
    output logic               flush_done
`ifdef DSP_ARB_GRANT_CNT_EN
    ,
    output logic [GNT_CNT_W-1:0] gnt_cnt0,
    output logic [GNT_CNT_W-1:0] gnt_cnt1
`endif
);

    arb_state_e         state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               hs, gnt_id, tags_busy;
    logic [TAG_W-1:0]   tag_q [0:PIPE_LAT];
    logic [A_WIDTH-1:0] dsp_a_q;
    logic [B_WIDTH-1:0] dsp_b_q;
    logic               dsp_ce_q, rsp0_q, rsp1_q;
    logic [P_WIDTH-1:0] rsp_p_q;

    // Pointer holds the last granted requester; a tie goes to the other one.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == RUN) begin
            if (req0_valid && (!req1_valid || ptr_q)) req0_ready = 1'b1;
            else if (req1_valid)                      req1_ready = 1'b1;
        end
    end

    assign hs     = req0_ready | req1_ready;
    assign gnt_id = req1_ready;
    assign ptr_d  = hs ? gnt_id : ptr_q;

    generate
        for (genvar k = 0; k <= PIPE_LAT; k++) begin : g_tag
            if (k == 0) begin : g_head
                Register #(.WIDTH(TAG_W), .RST_TYPE("ASYNC")) u_stage (
                    .clk_i(clk), .rst_i(rst), .en_i(1'b1),
                    .d_i({hs, gnt_id}), .q_o(tag_q[k])
                );
            end else begin : g_body
                Register #(.WIDTH(TAG_W), .RST_TYPE("ASYNC")) u_stage (
                    .clk_i(clk), .rst_i(rst), .en_i(1'b1),
                    .d_i(tag_q[k-1]), .q_o(tag_q[k])
                );
            end
        end
    endgenerate

    always_comb begin
        tags_busy = 1'b0;
        for (int k = 0; k <= PIPE_LAT; k++) tags_busy = tags_busy | tag_q[k][1];
    end

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (!tags_busy) begin
                         state_d    = RUN;
                         flush_done = 1'b1;
                     end
            default: state_d = RUN;
        endcase
    end

    // Last tag stage lines up with dsp_p; the response is registered one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            ptr_q    <= 1'b1;
            dsp_a_q  <= '0;
            dsp_b_q  <= '0;
            dsp_ce_q <= 1'b0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            rsp_p_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dsp_ce_q <= hs;
            if (hs) begin
                dsp_a_q <= gnt_id ? req1_a : req0_a;
                dsp_b_q <= gnt_id ? req1_b : req0_b;
            end
            rsp0_q <= tag_q[PIPE_LAT][1] & ~tag_q[PIPE_LAT][0];
            rsp1_q <= tag_q[PIPE_LAT][1] &  tag_q[PIPE_LAT][0];
            if (tag_q[PIPE_LAT][1]) rsp_p_q <= dsp_p;
        end
    end

    assign dsp_a      = dsp_a_q;
    assign dsp_b      = dsp_b_q;
    assign dsp_ce     = dsp_ce_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_p      = rsp_p_q;

`ifdef DSP_ARB_GRANT_CNT_EN
    logic [GNT_CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Scoreboard bench for dsp_mul_arbiter with a behavioural PIPE_LAT-deep DSP.
// Counter checks are compiled when DSP_ARB_GRANT_CNT_EN is defined.
module tb_dsp_mul_arbiter;

    localparam int AW  = 18;
    localparam int BW  = 18;
    localparam int PW  = 36;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_a = '0, req1_a = '0;
    logic [BW-1:0] req0_b = '0, req1_b = '0;
    logic [AW-1:0] dsp_a;
    logic [BW-1:0] dsp_b;
    logic          dsp_ce;
    logic [PW-1:0] dsp_p;
    logic          rsp0_valid, rsp1_valid;
    logic [PW-1:0] rsp_p;
    logic          flush = 1'b0;
    logic          flush_done;
`ifdef DSP_ARB_GRANT_CNT_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    dsp_mul_arbiter #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_p(rsp_p),
        .flush(flush), .flush_done(flush_done)
`ifdef DSP_ARB_GRANT_CNT_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    // Behavioural DSP slice: product appears LAT cycles after dsp_ce.
    logic [PW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= dsp_ce ? (PW'(dsp_a) * PW'(dsp_b)) : '0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dsp_p = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          id;
        logic [PW-1:0] p;
        int            at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void expect_rsp(logic id, logic [PW-1:0] p);
        exp_t e;
        e.id = id;
        e.p  = p;
        e.at = cyc + LAT + 2;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready && req1_ready) check("ready_exclusive", 2'b11, 2'b01);
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_id", {rsp1_valid, rsp0_valid}, mon_e.id ? 2'b10 : 2'b01);
                    check("rsp_p", rsp_p, mon_e.p);
                    check("rsp_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_dsp_ce"}, dsp_ce, 0);
        check({tag, "_dsp_a"}, dsp_a, 0);
        check({tag, "_dsp_b"}, dsp_b, 0);
        check({tag, "_rsp_v"}, {rsp1_valid, rsp0_valid}, 0);
        check({tag, "_rsp_p"}, rsp_p, 0);
        check({tag, "_flush_done"}, flush_done, 0);
    endtask

    initial begin
        idle(3);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("reset_ready", {req1_ready, req0_ready}, 0);

        // Single requester 0: 3*5=15, issued next cycle, response 6 cycles later
        req0_valid = 1'b1; req0_a = 18'd3; req0_b = 18'd5;
        expect_rsp(1'b0, 36'd15);
        @(negedge clk);
        check("single_ready", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("issue_ce", dsp_ce, 1);
        check("issue_a", dsp_a, 3);
        check("issue_b", dsp_b, 5);
        tick();
        @(negedge clk);
        check("idle_ce", dsp_ce, 0);
        check("hold_a", dsp_a, 3);
        idle(8);

        // Requester 1 alone with full-scale operands
        req1_valid = 1'b1; req1_a = 18'h3FFFF; req1_b = 18'h3FFFF;
        expect_rsp(1'b1, 36'hFFFF80001);
        @(negedge clk);
        check("single1_ready", {req1_ready, req0_ready}, 2'b10);
        tick();
        req1_valid = 1'b0;
        idle(9);

        // Both valid from reset: grants 0,1,0,1
        do_reset();
        req0_a = 18'd2; req0_b = 18'd7;
        req1_a = 18'd4; req1_b = 18'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expect_rsp(1'b0, 36'd14);
            else            expect_rsp(1'b1, 36'd36);
            @(negedge clk);
            check("rr_ready", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(10);

        // Flush with two issues in flight
        do_reset();
        req0_valid = 1'b1; req0_a = 18'd6; req0_b = 18'd7;
        expect_rsp(1'b0, 36'd42);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 18'd5; req1_b = 18'd5;
        expect_rsp(1'b1, 36'd25);
        tick();
        req1_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_done", flush_done, 0);
        tick();
        flush = 1'b0;
        req0_valid = 1'b1; req0_a = 18'd1; req0_b = 18'd1;
        for (int j = 3; j <= 6; j++) begin
            @(negedge clk);
            check("drain_ready", {req1_ready, req0_ready}, 0);
            check("drain_done", flush_done, 0);
            tick();
        end
        @(negedge clk);
        check("drain_last_ready", {req1_ready, req0_ready}, 0);
        check("drain_done_pulse", flush_done, 1);
        tick();
        expect_rsp(1'b0, 36'd1);
        @(negedge clk);
        check("post_drain_ready", {req1_ready, req0_ready}, 2'b01);
        check("post_drain_done", flush_done, 0);
        tick();
        req0_valid = 1'b0;
        idle(9);

        // Flush with empty pipeline: done pulse the following cycle only
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("empty_flush_done", flush_done, 1);
        tick();
        @(negedge clk);
        check("empty_flush_clear", flush_done, 0);

        // Reset mid-operation discards in-flight issues
        do_reset();
        req0_valid = 1'b1; req0_a = 18'd2; req0_b = 18'd3;
        idle(3);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        idle(2);
        rst = 1'b0;
        idle(12);

`ifdef DSP_ARB_GRANT_CNT_EN
        do_reset();
        check("cnt0_reset", gnt_cnt0, 0);
        check("cnt1_reset", gnt_cnt1, 0);
        req0_valid = 1'b1; req0_a = 18'd1; req0_b = 18'd1;
        for (int i = 0; i < 65537; i++) begin
            expect_rsp(1'b0, 36'd1);
            tick();
        end
        req0_valid = 1'b0;
        @(negedge clk);
        check("cnt0_wrap", gnt_cnt0, 1);
        check("cnt1_idle", gnt_cnt1, 0);
        idle(10);
`endif

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
